// File: rtl/axi_pv_pkg.sv
// Shared encodings for the AXI write protocol engine: burst/response codes,
// FSM state types and sticky error bit positions.
package axi_pv_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic {
        AW_WAIT   = 1'b0,
        AW_ASSERT = 1'b1
    } aw_state_e;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_BURST = 1'b1
    } w_state_e;

    localparam int ERR_B_ORPHAN = 0;
    localparam int ERR_WRAP_LEN = 1;
    localparam int ERR_4KB      = 2;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_pv_sync_fifo.sv
// Small synchronous FIFO with same-cycle push/pop; queues burst lengths
// from the AW side to the W side.
module axi_pv_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rd_ptr_q];

    // Pointer and occupancy registers; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage is not reset; entries are only read while cnt_q marks them valid.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/axi_wr_proto_outq.sv
// AXI write-path protocol engine: registered AW issue, WLAST generation from a
// per-burst beat counter, outstanding/completion tracking and sticky errors.
module axi_wr_proto_outq
    import axi_pv_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int IDW     = 4,
    parameter int MAX_OUT = 4
) (
    input  logic            axi_aclk,
    input  logic            axi_aresetn,
    input  logic            awvalid_in,
    output logic            awready_out,
    input  logic [IDW-1:0]  awid_in,
    input  logic [AW-1:0]   awaddr_in,
    input  logic [7:0]      awlen_in,
    input  logic [2:0]      awsize_in,
    input  logic [1:0]      awburst_in,
    input  logic            wvalid_in,
    output logic            wready_out,
    input  logic [DW-1:0]   wdata_in,
    input  logic [DW/8-1:0] wstrb_in,
    output logic            bvalid_out,
    input  logic            bready_in,
    output logic [IDW-1:0]  bid_out,
    output logic [1:0]      bresp_out,
    output logic [IDW-1:0]  axi_awid,
    output logic [AW-1:0]   axi_awaddr,
    output logic [7:0]      axi_awlen,
    output logic [2:0]      axi_awsize,
    output logic [1:0]      axi_awburst,
    output logic            axi_awvalid,
    input  logic            axi_awready,
    output logic [DW-1:0]   axi_wdata,
    output logic [DW/8-1:0] axi_wstrb,
    output logic            axi_wlast,
    output logic            axi_wvalid,
    input  logic            axi_wready,
    input  logic [IDW-1:0]  axi_bid,
    input  logic [1:0]      axi_bresp,
    input  logic            axi_bvalid,
    output logic            axi_bready,
    output logic [2:0]      err
);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int EW = AW + 9;

    aw_state_e      aw_state_q, aw_state_d;
    w_state_e       w_state_q, w_state_d;
    logic [IDW-1:0] awid_q, awid_d;
    logic [AW-1:0]  awaddr_q, awaddr_d;
    logic [7:0]     awlen_q, awlen_d;
    logic [2:0]     awsize_q, awsize_d;
    logic [1:0]     awburst_q, awburst_d;
    logic [7:0]     cur_len_q, cur_len_d;
    logic [7:0]     beat_q, beat_d;
    logic [CW-1:0]  out_cnt_q, out_cnt_d;
    logic [CW-1:0]  wdone_cnt_q, wdone_cnt_d;
    logic [2:0]     err_q, err_d;

    logic           lenq_push_s, lenq_pop_s, lenq_full_s, lenq_empty_s;
    logic [7:0]     lenq_rdata_s;
    logic           aw_hs_s, w_hs_s, wdone_inc_s, b_hs_s, b_orphan_s, b_dec_s;
    logic [EW-1:0]  aw_end_s;
    logic           cross_4k_s;

    axi_pv_sync_fifo #(.DEPTH(MAX_OUT), .WIDTH(8)) u_lenq (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .push_i  (lenq_push_s),
        .wdata_i (awlen_q),
        .pop_i   (lenq_pop_s),
        .rdata_o (lenq_rdata_s),
        .full_o  (lenq_full_s),
        .empty_o (lenq_empty_s)
    );

    assign aw_hs_s     = awvalid_in && awready_out;
    assign lenq_push_s = (aw_state_q == AW_ASSERT) && axi_awready;
    assign lenq_pop_s  = (w_state_q == W_IDLE) && !lenq_empty_s;
    assign w_hs_s      = (w_state_q == W_BURST) && wvalid_in && axi_wready;
    assign wdone_inc_s = w_hs_s && axi_wlast;
    assign b_hs_s      = axi_bvalid && bready_in;
    // A B with nothing completed is flagged and must not drag the counters below zero.
    assign b_orphan_s  = b_hs_s && (wdone_cnt_q == '0) && !wdone_inc_s;
    assign b_dec_s     = b_hs_s && !b_orphan_s;

    // Shifting the whole vector folds any carry past AW bits into the page compare.
    assign aw_end_s   = EW'(awaddr_in) + ((EW'(awlen_in) + EW'(1)) << awsize_in) - EW'(1);
    assign cross_4k_s = (aw_end_s >> 12) != (EW'(awaddr_in) >> 12);

    assign axi_awid    = awid_q;
    assign axi_awaddr  = awaddr_q;
    assign axi_awlen   = awlen_q;
    assign axi_awsize  = awsize_q;
    assign axi_awburst = awburst_q;
    assign axi_awvalid = (aw_state_q == AW_ASSERT);
    assign axi_wdata   = wdata_in;
    assign axi_wstrb   = wstrb_in;
    assign bvalid_out  = axi_bvalid;
    assign axi_bready  = bready_in;
    assign bid_out     = axi_bid;
    assign bresp_out   = axi_bresp;
    assign err         = err_q;

    // State and payload registers.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            aw_state_q  <= AW_WAIT;
            w_state_q   <= W_IDLE;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= 8'd0;
            awsize_q    <= 3'd0;
            awburst_q   <= 2'd0;
            cur_len_q   <= 8'd0;
            beat_q      <= 8'd0;
            out_cnt_q   <= '0;
            wdone_cnt_q <= '0;
            err_q       <= 3'd0;
        end else begin
            aw_state_q  <= aw_state_d;
            w_state_q   <= w_state_d;
            awid_q      <= awid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            cur_len_q   <= cur_len_d;
            beat_q      <= beat_d;
            out_cnt_q   <= out_cnt_d;
            wdone_cnt_q <= wdone_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic for both FSMs, counters and sticky errors.
    always_comb begin
        aw_state_d  = aw_state_q;
        w_state_d   = w_state_q;
        awid_d      = awid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
        awburst_d   = awburst_q;
        cur_len_d   = cur_len_q;
        beat_d      = beat_q;

        case (aw_state_q)
            AW_WAIT: begin
                if (aw_hs_s) begin
                    awid_d     = awid_in;
                    awaddr_d   = awaddr_in;
                    awlen_d    = awlen_in;
                    awsize_d   = awsize_in;
                    awburst_d  = awburst_in;
                    aw_state_d = AW_ASSERT;
                end else begin
                    aw_state_d = AW_WAIT;
                end
            end
            AW_ASSERT: begin
                if (axi_awready) aw_state_d = AW_WAIT;
                else             aw_state_d = AW_ASSERT;
            end
            default: aw_state_d = AW_WAIT;
        endcase

        case (w_state_q)
            W_IDLE: begin
                if (!lenq_empty_s) begin
                    cur_len_d = lenq_rdata_s;
                    beat_d    = 8'd0;
                    w_state_d = W_BURST;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_BURST: begin
                if (w_hs_s) begin
                    beat_d = beat_q + 8'd1;
                    if (axi_wlast) w_state_d = W_IDLE;
                    else           w_state_d = W_BURST;
                end else begin
                    w_state_d = W_BURST;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        out_cnt_d   = out_cnt_q + CW'(lenq_push_s) - CW'(b_dec_s);
        wdone_cnt_d = wdone_cnt_q + CW'(wdone_inc_s) - CW'(b_dec_s);

        err_d = err_q;
        err_d[ERR_B_ORPHAN] = err_q[ERR_B_ORPHAN] | b_orphan_s;
        err_d[ERR_WRAP_LEN] = err_q[ERR_WRAP_LEN] |
                              (aw_hs_s && (awburst_in == BURST_WRAP) && !wrap_len_ok(awlen_in));
        err_d[ERR_4KB]      = err_q[ERR_4KB] |
                              (aw_hs_s && (awburst_in == BURST_INCR) && cross_4k_s);
    end

    // Handshake-facing outputs derived from the current FSM states.
    always_comb begin
        awready_out = 1'b0;
        wready_out  = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        if (aw_state_q == AW_WAIT) begin
            awready_out = (out_cnt_q < CW'(MAX_OUT)) && !lenq_full_s;
        end else begin
            awready_out = 1'b0;
        end
        if (w_state_q == W_BURST) begin
            axi_wvalid = wvalid_in;
            wready_out = axi_wready;
            axi_wlast  = (beat_q == cur_len_q);
        end else begin
            axi_wvalid = 1'b0;
            wready_out = 1'b0;
            axi_wlast  = 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_wr_proto_outq.sv
// Self-checking bench for axi_wr_proto_outq: directed scenarios plus randomized
// bursts checked against a page/legality model built from plain arithmetic.
module tb_axi_wr_proto_outq;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int IDW = 4;
    localparam int PW  = IDW + AW + 13;

    logic clk = 1'b0;
    logic axi_aresetn;
    logic awvalid_in, awready_out;
    logic [IDW-1:0] awid_in;
    logic [AW-1:0] awaddr_in;
    logic [7:0] awlen_in;
    logic [2:0] awsize_in;
    logic [1:0] awburst_in;
    logic wvalid_in, wready_out;
    logic [DW-1:0] wdata_in;
    logic [DW/8-1:0] wstrb_in;
    logic bvalid_out, bready_in;
    logic [IDW-1:0] bid_out;
    logic [1:0] bresp_out;
    logic [IDW-1:0] axi_awid;
    logic [AW-1:0] axi_awaddr;
    logic [7:0] axi_awlen;
    logic [2:0] axi_awsize;
    logic [1:0] axi_awburst;
    logic axi_awvalid, axi_awready;
    logic [DW-1:0] axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic axi_wlast, axi_wvalid, axi_wready;
    logic [IDW-1:0] axi_bid;
    logic [1:0] axi_bresp;
    logic axi_bvalid, axi_bready;
    logic [2:0] err;

    int n_checks = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axi_wr_proto_outq #(.AW(AW), .DW(DW), .IDW(IDW), .MAX_OUT(4)) dut (
        .axi_aclk(clk), .axi_aresetn(axi_aresetn),
        .awvalid_in(awvalid_in), .awready_out(awready_out), .awid_in(awid_in),
        .awaddr_in(awaddr_in), .awlen_in(awlen_in), .awsize_in(awsize_in), .awburst_in(awburst_in),
        .wvalid_in(wvalid_in), .wready_out(wready_out), .wdata_in(wdata_in), .wstrb_in(wstrb_in),
        .bvalid_out(bvalid_out), .bready_in(bready_in), .bid_out(bid_out), .bresp_out(bresp_out),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready), .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .err(err)
    );

    // Reference rules: a burst's last byte must sit in the same 4KB page as its first.
    function automatic bit crosses_4k(input longint unsigned addr, input int len, input int size);
        longint unsigned last_byte;
        last_byte = addr + (longint'(len + 1) << size) - 1;
        return (addr / 4096) != (last_byte / 4096);
    endfunction

    function automatic bit wrap_len_bad(input int len);
        return !(len == 1 || len == 3 || len == 7 || len == 15);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        axi_aresetn = 1'b0;
        awvalid_in = 1'b0; awid_in = '0; awaddr_in = '0; awlen_in = 8'd0; awsize_in = 3'd0; awburst_in = 2'd0;
        wvalid_in = 1'b0; wdata_in = '0; wstrb_in = '0; bready_in = 1'b1;
        axi_awready = 1'b1; axi_wready = 1'b1; axi_bvalid = 1'b0; axi_bid = '0; axi_bresp = 2'd0;
        tick();
        tick();
        axi_aresetn = 1'b1;
    endtask

    // Presents one upstream AW and returns just after the handshake edge.
    task automatic aw_up(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output bit ok);
        ok = 1'b0;
        awvalid_in = 1'b1; awid_in = id; awaddr_in = addr; awlen_in = len; awsize_in = size; awburst_in = burst;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (awready_out) ok = 1'b1;
            tick();
        end
        awvalid_in = 1'b0;
    endtask

    // Stalls axi_awready for dly clocks (offering W meanwhile), then captures the AXI AW payload.
    task automatic aw_axi(input int dly, output int early, output bit ok, output logic [PW-1:0] pay);
        early = 0;
        axi_awready = 1'b0;
        for (int i = 0; i < dly; i++) begin
            wvalid_in = 1'b1;
            #1;
            if (axi_wvalid || wready_out || !axi_awvalid) early++;
            tick();
        end
        wvalid_in = 1'b0;
        axi_awready = 1'b1;
        #1;
        ok = axi_awvalid;
        pay = {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst};
        tick();
    endtask

    // Drives len+1 beats; mode 0 wready=1, 1 random, 2 toggling from 0. Counts protocol deviations.
    task automatic w_burst(input int len, input int mode, output int bad, output bit ok);
        int beat;
        logic [DW-1:0] d;
        logic [DW/8-1:0] s;
        bad = 0; ok = 1'b0; beat = 0;
        d = {$urandom, $urandom}; s = DW'(0) | $urandom;
        for (int c = 0; c < 300 && !ok; c++) begin
            case (mode)
                0: axi_wready = 1'b1;
                1: axi_wready = 1'($urandom_range(0, 1));
                default: axi_wready = (c % 2 == 1);
            endcase
            wvalid_in = 1'b1; wdata_in = d; wstrb_in = s;
            #1;
            if (axi_wvalid && (axi_wdata !== d || axi_wstrb !== s)) bad++;
            if (axi_wvalid && axi_wlast !== (beat == len)) bad++;
            if (wready_out) begin
                if (beat == len) ok = 1'b1;
                beat++;
                d = {$urandom, $urandom}; s = 8'($urandom);
            end
            tick();
        end
        wvalid_in = 1'b0;
        axi_wready = 1'b1;
    endtask

    task automatic b_chan(input logic [IDW-1:0] id, input logic [1:0] resp, output logic [IDW+3:0] obs);
        axi_bvalid = 1'b1; axi_bid = id; axi_bresp = resp; bready_in = 1'b1;
        #1;
        obs = {bvalid_out, axi_bready, bid_out, bresp_out};
        tick();
        axi_bvalid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        wvalid_in = 1'b1;
        #1;
        n_checks++; if ({axi_awvalid, axi_wvalid, wready_out, bvalid_out} !== 4'b0000) $display("FAIL reset_valids: got %b want 0000", {axi_awvalid, axi_wvalid, wready_out, bvalid_out}); else n_pass++;
        n_checks++; if (err !== 3'b000) $display("FAIL reset_err: got %b want 000", err); else n_pass++;
        n_checks++; if (awready_out !== 1'b1) $display("FAIL reset_awready: got %b want 1", awready_out); else n_pass++;
        n_checks++; if ({axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst} !== {PW{1'b0}}) $display("FAIL reset_payload: got %h want 0", {axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst}); else n_pass++;
        wvalid_in = 1'b0;
    endtask

    task automatic test_single();
        bit ok; int early, bad; logic [PW-1:0] pay; logic [IDW+3:0] obs;
        apply_reset();
        aw_up(4'h5, 32'h0000_1000, 8'd3, 3'd3, 2'd1, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL single_aw_up: got %b want 1", ok); else n_pass++;
        aw_axi(0, early, ok, pay);
        n_checks++; if (ok !== 1'b1) $display("FAIL single_aw_latency: awvalid %b want 1 one clk after handshake", ok); else n_pass++;
        n_checks++; if (pay !== {4'h5, 32'h0000_1000, 8'd3, 3'd3, 2'd1}) $display("FAIL single_aw_payload: got %h want %h", pay, {4'h5, 32'h0000_1000, 8'd3, 3'd3, 2'd1}); else n_pass++;
        w_burst(3, 0, bad, ok);
        n_checks++; if (ok !== 1'b1 || bad != 0) $display("FAIL single_w_beats: done %b deviations %0d want 1/0", ok, bad); else n_pass++;
        b_chan(4'h5, 2'd0, obs);
        n_checks++; if (obs !== {2'b11, 4'h5, 2'd0}) $display("FAIL single_b: got %h want %h", obs, {2'b11, 4'h5, 2'd0}); else n_pass++;
        #1;
        n_checks++; if (err !== 3'b000) $display("FAIL single_err: got %b want 000", err); else n_pass++;
    endtask

    task automatic test_outstanding();
        bit ok; int nok, bad, badsum; logic [IDW+3:0] obs;
        apply_reset();
        nok = 0;
        for (int k = 0; k < 4; k++) begin
            aw_up(4'(k), 32'h100 * k, 8'd0, 3'd3, 2'd1, ok);
            if (ok) nok++;
        end
        n_checks++; if (nok != 4) $display("FAIL outq_accept: got %0d want 4", nok); else n_pass++;
        tick();
        #1;
        n_checks++; if (awready_out !== 1'b0) $display("FAIL outq_full_awready: got %b want 0", awready_out); else n_pass++;
        w_burst(0, 0, bad, ok);
        #1;
        n_checks++; if (awready_out !== 1'b0) $display("FAIL outq_still_full: got %b want 0", awready_out); else n_pass++;
        b_chan(4'h0, 2'd0, obs);
        #1;
        n_checks++; if (awready_out !== 1'b1) $display("FAIL outq_release: got %b want 1", awready_out); else n_pass++;
        badsum = bad + (ok ? 0 : 1);
        for (int k = 1; k < 4; k++) begin
            w_burst(0, 0, bad, ok);
            badsum += bad + (ok ? 0 : 1);
            b_chan(4'(k), 2'd0, obs);
        end
        #1;
        n_checks++; if (badsum != 0) $display("FAIL outq_w_drain: got %0d deviations want 0", badsum); else n_pass++;
        n_checks++; if (err !== 3'b000) $display("FAIL outq_err: got %b want 000", err); else n_pass++;
    endtask

    task automatic test_len0_toggle();
        bit ok, aok; int early, bad; logic [PW-1:0] pay; logic [IDW+3:0] obs;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            aw_up(4'(k + 8), 32'h4000 + 32'h40 * k, 8'd0, 3'd2, 2'd1, aok);
            aw_axi(0, early, ok, pay);
            w_burst(0, 2, bad, ok);
            n_checks++; if (!aok || !ok || bad != 0) $display("FAIL len0_toggle_%0d: aw %b done %b deviations %0d", k, aok, ok, bad); else n_pass++;
            b_chan(4'(k + 8), 2'd0, obs);
        end
    endtask

    task automatic test_errors();
        bit ok;
        apply_reset();
        aw_up(4'h1, 32'h0000_0040, 8'd2, 3'd3, 2'd2, ok);
        #1;
        n_checks++; if (err !== 3'b010) $display("FAIL wrap_len_err: got %b want 010", err); else n_pass++;
        aw_up(4'h2, 32'h0000_0FF8, 8'd1, 3'd3, 2'd1, ok);
        #1;
        n_checks++; if (err !== 3'b110) $display("FAIL err_sticky: got %b want 110", err); else n_pass++;
        apply_reset();
        #1;
        n_checks++; if (err !== 3'b000) $display("FAIL err_clear: got %b want 000", err); else n_pass++;
        aw_up(4'h2, 32'h0000_0FF8, 8'd1, 3'd3, 2'd1, ok);
        #1;
        n_checks++; if (err !== 3'b100) $display("FAIL incr_4k_cross: got %b want 100", err); else n_pass++;
        apply_reset();
        aw_up(4'h3, 32'h0000_0FF0, 8'd1, 3'd3, 2'd1, ok);
        aw_up(4'h4, 32'h0000_0000, 8'd3, 3'd2, 2'd2, ok);
        aw_up(4'h5, 32'h0000_0FF8, 8'd1, 3'd3, 2'd0, ok);
        #1;
        n_checks++; if (err !== 3'b000) $display("FAIL legal_bursts_err: got %b want 000", err); else n_pass++;
    endtask

    task automatic test_orphan_b();
        bit ok; int early; logic [PW-1:0] pay; logic [IDW+3:0] obs;
        apply_reset();
        b_chan(4'h7, 2'd2, obs);
        #1;
        n_checks++; if (err !== 3'b001) $display("FAIL orphan_b_err: got %b want 001", err); else n_pass++;
        n_checks++; if (awready_out !== 1'b1) $display("FAIL orphan_b_counter: awready %b want 1", awready_out); else n_pass++;
        apply_reset();
        aw_up(4'h6, 32'h0000_0100, 8'd0, 3'd3, 2'd1, ok);
        aw_axi(0, early, ok, pay);
        tick();
        wvalid_in = 1'b1; wdata_in = 64'h1234_5678_9ABC_DEF0; axi_wready = 1'b1;
        axi_bvalid = 1'b1; axi_bid = 4'h6; axi_bresp = 2'd0;
        #1;
        n_checks++; if ({wready_out, axi_wlast} !== 2'b11) $display("FAIL same_clk_setup: got %b want 11", {wready_out, axi_wlast}); else n_pass++;
        tick();
        wvalid_in = 1'b0; axi_bvalid = 1'b0;
        #1;
        n_checks++; if (err !== 3'b000) $display("FAIL same_clk_wlast_b: got %b want 000", err); else n_pass++;
        n_checks++; if (awready_out !== 1'b1) $display("FAIL same_clk_outcnt: awready %b want 1", awready_out); else n_pass++;
        b_chan(4'h6, 2'd0, obs);
        #1;
        n_checks++; if (err !== 3'b001) $display("FAIL same_clk_net_zero: got %b want 001", err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, aok; int early, bad, beats; logic [PW-1:0] pay; logic [IDW+3:0] obs;
        apply_reset();
        aw_up(4'h3, 32'h0000_2000, 8'd7, 3'd3, 2'd1, ok);
        aw_axi(0, early, ok, pay);
        beats = 0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            wvalid_in = 1'b1; wdata_in = {$urandom, $urandom};
            #1;
            if (wready_out) beats++;
            tick();
        end
        wvalid_in = 1'b1;
        #1;
        n_checks++; if ({wready_out, axi_wlast} !== 2'b10) $display("FAIL mid_setup: got %b want 10", {wready_out, axi_wlast}); else n_pass++;
        axi_aresetn = 1'b0;
        tick();
        axi_aresetn = 1'b1;
        #1;
        n_checks++; if ({axi_awvalid, axi_wvalid, wready_out, bvalid_out, err} !== 7'b0) $display("FAIL mid_reset_state: got %b want 0000000", {axi_awvalid, axi_wvalid, wready_out, bvalid_out, err}); else n_pass++;
        tick();
        #1;
        n_checks++; if ({wready_out, awready_out} !== 2'b01) $display("FAIL mid_reset_fifo_empty: got %b want 01", {wready_out, awready_out}); else n_pass++;
        wvalid_in = 1'b0;
        aw_up(4'h9, 32'h0000_3000, 8'd3, 3'd3, 2'd1, aok);
        aw_axi(1, early, ok, pay);
        n_checks++; if (!aok || !ok || early != 0) $display("FAIL post_reset_aw: aw %b axi %b early %0d", aok, ok, early); else n_pass++;
        w_burst(3, 1, bad, ok);
        n_checks++; if (!ok || bad != 0) $display("FAIL post_reset_w: done %b deviations %0d", ok, bad); else n_pass++;
        b_chan(4'h9, 2'd0, obs);
        #1;
        n_checks++; if ({obs, err} !== {2'b11, 4'h9, 2'd0, 3'b000}) $display("FAIL post_reset_b: got %h want %h", {obs, err}, {2'b11, 4'h9, 2'd0, 3'b000}); else n_pass++;
    endtask

    task automatic test_random();
        bit ok, aok; int early, bad, dly;
        logic [PW-1:0] pay; logic [IDW+3:0] obs; logic [2:0] exp_e;
        logic [IDW-1:0] id; logic [AW-1:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst, resp;
        apply_reset();
        exp_e = 3'b000;
        for (int it = 0; it < 16; it++) begin
            id = 4'($urandom); addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
            len = 8'($urandom_range(0, 15)); size = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 2)); resp = 2'($urandom); dly = $urandom_range(0, 2);
            if (burst == 2'd2 && wrap_len_bad(int'(len))) exp_e[1] = 1'b1;
            if (burst == 2'd1 && crosses_4k(longint'(addr), int'(len), int'(size))) exp_e[2] = 1'b1;
            aw_up(id, addr, len, size, burst, aok);
            aw_axi(dly, early, ok, pay);
            n_checks++; if (!aok || !ok || early != 0) $display("FAIL rnd_aw_%0d: aw %b axi %b early %0d", it, aok, ok, early); else n_pass++;
            n_checks++; if (pay !== {id, addr, len, size, burst}) $display("FAIL rnd_payload_%0d: got %h want %h", it, pay, {id, addr, len, size, burst}); else n_pass++;
            w_burst(int'(len), 1, bad, ok);
            n_checks++; if (!ok || bad != 0) $display("FAIL rnd_w_%0d: done %b deviations %0d", it, ok, bad); else n_pass++;
            b_chan(id, resp, obs);
            #1;
            n_checks++; if (obs !== {2'b11, id, resp}) $display("FAIL rnd_b_%0d: got %h want %h", it, obs, {2'b11, id, resp}); else n_pass++;
            n_checks++; if (err !== exp_e) $display("FAIL rnd_err_%0d: got %b want %b", it, err, exp_e); else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_outstanding();
        test_len0_toggle();
        test_errors();
        test_orphan_b();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
